// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce; one key_en strobe per accepted press.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 20
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_en
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TICKS);

`ifdef KEY_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                            REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HOLD_DELAY = HW'(REPEAT_DELAY_TICKS);
  localparam logic [HW-1:0] HOLD_RATE  = HW'(REPEAT_RATE_TICKS);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_next;
  logic [3:0]    col_meta, col_s;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    row_idx, row_idx_next;
  logic [1:0]    col_idx, col_idx_next;
  logic [1:0]    col_pick;
  logic          col_any, col_low;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic [DW-1:0] rel_cnt, rel_cnt_next;
  logic [3:0]    key_code_next;
  logic          key_en_next;

`ifdef KEY_REPEAT_EN
  logic [HW-1:0] hold_cnt, hold_cnt_next, hold_inc, hold_limit;
  logic          repeating, repeating_next;
`endif

  // Two-flop synchronizer on the asynchronous column inputs, plus the scan tick divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
      div_cnt  <= '0;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign col_any = (col_s != 4'hF);
  assign col_low = ~col_s[col_idx];
  assign row_out = ~(4'b0001 << row_idx);

  always_comb begin
    casez (col_s)
      4'b???0: col_pick = 2'd0;
      4'b??01: col_pick = 2'd1;
      4'b?011: col_pick = 2'd2;
      default: col_pick = 2'd3;
    endcase
  end

`ifdef KEY_REPEAT_EN
  assign hold_inc   = hold_cnt + 1'b1;
  assign hold_limit = repeating ? HOLD_RATE : HOLD_DELAY;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next    = state;
    row_idx_next  = row_idx;
    col_idx_next  = col_idx;
    deb_cnt_next  = deb_cnt;
    rel_cnt_next  = rel_cnt;
    key_code_next = key_code;
    key_en_next   = 1'b0;
`ifdef KEY_REPEAT_EN
    hold_cnt_next  = hold_cnt;
    repeating_next = repeating;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (col_any) begin
            col_idx_next = col_pick;
            deb_cnt_next = '0;
            state_next   = DEBOUNCE;
          end else begin
            row_idx_next = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_low) begin
            deb_cnt_next = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
            if (deb_cnt_next == DEB_MAX) begin
              key_code_next = {row_idx, col_idx};
              key_en_next   = 1'b1;
              rel_cnt_next  = '0;
              state_next    = HELD;
`ifdef KEY_REPEAT_EN
              hold_cnt_next  = '0;
              repeating_next = 1'b0;
`endif
            end
          end else begin
            state_next   = SCAN;
            row_idx_next = row_idx + 2'd1;
          end
        end
        HELD: begin
          if (col_low) begin
            rel_cnt_next = '0;
`ifdef KEY_REPEAT_EN
            if (hold_inc == hold_limit) begin
              key_en_next    = 1'b1;
              hold_cnt_next  = '0;
              repeating_next = 1'b1;
            end else begin
              hold_cnt_next = hold_inc;
            end
`endif
          end else begin
            rel_cnt_next = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + 1'b1;
            if (rel_cnt_next == DEB_MAX) state_next = SCAN;
`ifdef KEY_REPEAT_EN
            hold_cnt_next  = '0;
            repeating_next = 1'b0;
`endif
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= SCAN;
      row_idx  <= '0;
      col_idx  <= '0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
      key_code <= '0;
      key_en   <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_cnt  <= '0;
      repeating <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      row_idx  <= row_idx_next;
      col_idx  <= col_idx_next;
      deb_cnt  <= deb_cnt_next;
      rel_cnt  <= rel_cnt_next;
      key_code <= key_code_next;
      key_en   <= key_en_next;
`ifdef KEY_REPEAT_EN
      hold_cnt  <= hold_cnt_next;
      repeating <= repeating_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with a behavioural 4x4 keypad matrix model.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [3:0]  key_code;
  logic        key_en;
  logic [15:0] keys;

  int tests_run    = 0;
  int tests_failed = 0;

  int         cyc        = 0;
  int         pulse_cnt  = 0;
  int         consec_cnt = 0;
  logic       prev_en    = 1'b0;
  logic [3:0] last_code  = 4'd0;
  int         pulse_t    [0:63];
  logic [3:0] pulse_code [0:63];

  always #5 clk = ~clk;

  keypad_scanner #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_TICKS(DEB)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY_TICKS(8),
    .REPEAT_RATE_TICKS(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_out(row_out),
    .col_in(col_in),
    .key_code(key_code),
    .key_en(key_en)
  );

  // Keypad matrix: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_en) begin
      if (pulse_cnt < 64) begin
        pulse_t[pulse_cnt]    = cyc;
        pulse_code[pulse_cnt] = key_code;
      end
      pulse_cnt++;
      last_code = key_code;
    end
    if (key_en && prev_en) consec_cnt++;
    prev_en = key_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int target, input int budget, output bit ok);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    ok = (pulse_cnt >= target);
  endtask

  task automatic release_all;
    keys = '0;
    step(60);
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst  = 1'b1;
    keys = '0;
    step(3);
    tests_run++;
    if (row_out !== 4'b1110) begin
      tests_failed++;
      $display("FAIL reset_row_out: got %b expected 1110", row_out);
    end
    tests_run++;
    if (key_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_key_en: got %b expected 0", key_en);
    end
    tests_run++;
    if (key_code !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_key_code: got %0d expected 0", key_code);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp = ~(4'b0001 << ((i / 4) % 4));
      tests_run++;
      if (row_out !== exp) begin
        tests_failed++;
        $display("FAIL scan_row[%0d]: got %b expected %b", i, row_out, exp);
      end
      step(1);
    end
  endtask

  task automatic test_single_press;
    int base;
    bit ok;
    base = pulse_cnt;
    keys = 16'h0001 << 6;
    wait_pulse(base + 1, 34, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL press_1_2_latency: got %0d pulses expected %0d", pulse_cnt - base, 1);
    end
    tests_run++;
    if (last_code !== 4'd6) begin
      tests_failed++;
      $display("FAIL press_1_2_code: got %0d expected 6", last_code);
    end
`ifndef KEY_REPEAT_EN
    step(200);
    tests_run++;
    if (pulse_cnt !== base + 1) begin
      tests_failed++;
      $display("FAIL held_no_repeat: got %0d pulses expected 1", pulse_cnt - base);
    end
`endif
    release_all();
  endtask

  task automatic test_bounce;
    int base;
    bit ok;
    base = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      keys = 16'h0001 << 9;
      step(4);
      keys = '0;
      step(4);
    end
    tests_run++;
    if (pulse_cnt !== base) begin
      tests_failed++;
      $display("FAIL bounce_no_pulse: got %0d pulses expected 0", pulse_cnt - base);
    end
    keys = 16'h0001 << 9;
    wait_pulse(base + 1, 34, ok);
    tests_run++;
    if (!ok || last_code !== 4'd9) begin
      tests_failed++;
      $display("FAIL bounce_then_hold: got code %0d pulses %0d expected code 9 pulses 1",
               last_code, pulse_cnt - base);
    end
    step(8);
    release_all();
  endtask

  task automatic test_repress;
    int base;
    bit ok;
    base = pulse_cnt;
    keys = 16'h0001 << 14;
    wait_pulse(base + 1, 34, ok);
    tests_run++;
    if (!ok || last_code !== 4'd14) begin
      tests_failed++;
      $display("FAIL press_3_2: got code %0d pulses %0d expected code 14 pulses 1",
               last_code, pulse_cnt - base);
    end
    keys = '0;
    step(8);
    keys = 16'h0001 << 14;
    step(20);
    tests_run++;
    if (pulse_cnt !== base + 1) begin
      tests_failed++;
      $display("FAIL short_release_repress: got %0d pulses expected 1", pulse_cnt - base);
    end
    keys = '0;
    step(24);
    keys = 16'h0001 << 3;
    wait_pulse(base + 2, 34, ok);
    tests_run++;
    if (!ok || last_code !== 4'd3) begin
      tests_failed++;
      $display("FAIL press_0_3_after_release: got code %0d pulses %0d expected code 3 pulses 2",
               last_code, pulse_cnt - base);
    end
    step(8);
    release_all();
  endtask

  task automatic test_multi_key;
    int base;
    bit ok;
    base = pulse_cnt;
    keys = (16'h0001 << 1) | (16'h0001 << 3);
    wait_pulse(base + 1, 34, ok);
    tests_run++;
    if (!ok || last_code !== 4'd1) begin
      tests_failed++;
      $display("FAIL two_keys_row0: got code %0d pulses %0d expected code 1 pulses 1",
               last_code, pulse_cnt - base);
    end
    step(20);
    tests_run++;
    if (pulse_cnt !== base + 1) begin
      tests_failed++;
      $display("FAIL two_keys_single_pulse: got %0d pulses expected 1", pulse_cnt - base);
    end
    release_all();
  endtask

  task automatic test_reset_in_debounce;
    int base;
    bit ok;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
    base = pulse_cnt;
    keys = 16'h0001 << 5;
    step(12);
    tests_run++;
    if (row_out !== 4'b1101 || pulse_cnt !== base) begin
      tests_failed++;
      $display("FAIL debounce_in_progress: got row %b pulses %0d expected row 1101 pulses 0",
               row_out, pulse_cnt - base);
    end
    rst  = 1'b1;
    keys = '0;
    step(1);
    tests_run++;
    if (row_out !== 4'b1110 || key_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_during_debounce: got row %b en %b expected row 1110 en 0",
               row_out, key_en);
    end
    tests_run++;
    if (key_code !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_clears_code: got %0d expected 0", key_code);
    end
    rst = 1'b0;
    step(40);
    tests_run++;
    if (pulse_cnt !== base) begin
      tests_failed++;
      $display("FAIL pending_key_discarded: got %0d pulses expected 0", pulse_cnt - base);
    end
    keys = 16'h0001 << 13;
    wait_pulse(base + 1, 40, ok);
    tests_run++;
    if (!ok || last_code !== 4'd13) begin
      tests_failed++;
      $display("FAIL press_3_1_after_rst: got code %0d pulses %0d expected code 13 pulses 1",
               last_code, pulse_cnt - base);
    end
    step(8);
    release_all();
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    int base;
    int n;
    int gap;
    int exp_gap;
    base = pulse_cnt;
    keys = 16'h0001 << 0;
    step(120);
    keys = '0;
    step(60);
    n = pulse_cnt - base;
    tests_run++;
    if (n < 4) begin
      tests_failed++;
      $display("FAIL repeat_count: got %0d pulses expected at least 4", n);
    end
    for (int i = 0; i < n && base + i < 64; i++) begin
      tests_run++;
      if (pulse_code[base+i] !== 4'd0) begin
        tests_failed++;
        $display("FAIL repeat_code[%0d]: got %0d expected 0", i, pulse_code[base+i]);
      end
      if (i > 0) begin
        gap     = pulse_t[base+i] - pulse_t[base+i-1];
        exp_gap = (i == 1) ? 8 * CLK_DIV : 4 * CLK_DIV;
        tests_run++;
        if (gap !== exp_gap) begin
          tests_failed++;
          $display("FAIL repeat_gap[%0d]: got %0d clk expected %0d clk", i, gap, exp_gap);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back;
    tests_run++;
    if (consec_cnt !== 0) begin
      tests_failed++;
      $display("FAIL key_en_consecutive: got %0d double-high cycles expected 0", consec_cnt);
    end
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_repress();
    test_multi_key();
    test_reset_in_debounce();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
